// File: rtl/wrapped_instrumented_adder_kogge_block_pkg.sv
// Shared widths, control-word bit positions and pad bit positions for the
// instrumented Kogge-Stone adder wrapper.
package wrapped_instrumented_adder_kogge_block_pkg;

  localparam int WIDTH    = 32;
  localparam int IO_WIDTH = 38;

  // Bit positions inside the la1 control word
  localparam int CTRL_RUN        = 0;
  localparam int CTRL_CLEAR      = 1;
  localparam int CTRL_LOAD_A     = 2;
  localparam int CTRL_LOAD_B     = 3;
  localparam int CTRL_LOAD_EXT   = 4;
  localparam int CTRL_LOAD_RING  = 5;
  localparam int CTRL_LOAD_SMASK = 6;

  // Pad bit positions
  localparam int EXT_IN    = 8;
  localparam int CHAIN_OUT = 9;
  localparam int COUT_OUT  = 10;

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  typedef struct packed {
    logic run;
    logic clear;
    logic loadA;
    logic loadB;
    logic loadExt;
    logic loadRing;
    logic loadSMask;
  } ctrl_t;

  // Pull the named control strobes out of the raw control word
  function automatic ctrl_t decodeCtrl(input logic [WIDTH-1:0] word);
    ctrl_t c;
    c.run       = word[CTRL_RUN];
    c.clear     = word[CTRL_CLEAR];
    c.loadA     = word[CTRL_LOAD_A];
    c.loadB     = word[CTRL_LOAD_B];
    c.loadExt   = word[CTRL_LOAD_EXT];
    c.loadRing  = word[CTRL_LOAD_RING];
    c.loadSMask = word[CTRL_LOAD_SMASK];
    return c;
  endfunction

endpackage

// File: rtl/wrapped_instrumented_adder_kogge_block_kogge_stone_adder.sv
// Purely combinational Kogge-Stone parallel-prefix adder, carry-in tied to 0.
module kogge_stone_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] w_gLvl [0:LEVELS];
  logic [WIDTH-1:0] w_pLvl [0:LEVELS];

  // Prefix tree: level k combines each bit with the group 2^(k-1) positions below
  always_comb begin
    w_gLvl[0] = a & b;
    w_pLvl[0] = a ^ b;
    for (int k = 1; k <= LEVELS; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (k - 1))) begin
          w_gLvl[k][i] = w_gLvl[k-1][i] | (w_pLvl[k-1][i] & w_gLvl[k-1][i - (1 << (k - 1))]);
          w_pLvl[k][i] = w_pLvl[k-1][i] & w_pLvl[k-1][i - (1 << (k - 1))];
        end else begin
          w_gLvl[k][i] = w_gLvl[k-1][i];
          w_pLvl[k][i] = w_pLvl[k-1][i];
        end
      end
    end
  end

  // Bit i sums with the carry out of the prefix [i-1:0]
  always_comb begin
    sum  = w_pLvl[0] ^ {w_gLvl[LEVELS][WIDTH-2:0], 1'b0};
    cout = w_gLvl[LEVELS][WIDTH-1];
  end

endmodule

// File: rtl/wrapped_instrumented_adder_kogge_block.sv
// Wrapper around the Kogge-Stone adder: operand/mask registers loaded from the
// logic analyser, a feedback ring through the adder, and an edge counter.
module wrapped_instrumented_adder_kogge_block
  import wrapped_instrumented_adder_kogge_block_pkg::*;
(
  input  logic                wb_clk_i,
  input  logic                rst_n,
  input  logic                active,
  input  logic [WIDTH-1:0]    la1_data_in,
  output logic [WIDTH-1:0]    la1_data_out,
  input  logic [WIDTH-1:0]    la1_oenb,
  input  logic [WIDTH-1:0]    la2_data_in,
  output logic [WIDTH-1:0]    la2_data_out,
  input  logic [WIDTH-1:0]    la2_oenb,
  input  logic [WIDTH-1:0]    la3_data_in,
  output logic [WIDTH-1:0]    la3_data_out,
  input  logic [WIDTH-1:0]    la3_oenb,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out,
  output logic [IO_WIDTH-1:0] io_oeb
);

  ctrl_t            w_ctrl;
  logic [WIDTH-1:0] r_aInput;
  logic [WIDTH-1:0] r_bInput;
  logic [WIDTH-1:0] r_extMask;
  logic [WIDTH-1:0] r_ringMask;
  logic [WIDTH-1:0] r_sMask;
  logic             r_chainOut;
  logic [WIDTH-1:0] r_counter;

  logic [WIDTH-1:0] w_aEff;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_fb;
  logic             w_chainNext;
  logic             w_chainRise;

  assign w_ctrl = decodeCtrl(la1_data_in);

  // Operand select per bit: ring feedback beats the external pad, which beats a_input
  always_comb begin
    w_aEff = (r_ringMask & {WIDTH{r_chainOut}})
           | (~r_ringMask & r_extMask & {WIDTH{io_in[EXT_IN]}})
           | (~r_ringMask & ~r_extMask & r_aInput);
  end

  kogge_stone_adder #(
    .WIDTH(WIDTH)
  ) instrumented_adder (
    .a    (w_aEff),
    .b    (r_bInput),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Feedback taps the masked sum bits; the inverted parity closes the ring
  always_comb begin
    w_fb        = ^(w_sum & r_sMask);
    w_chainNext = ~w_fb;
    w_chainRise = w_ctrl.run & ~r_chainOut & w_chainNext;
  end

  // Level-sensitive loads of operands and masks, independent of each other
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_aInput   <= '0;
      r_bInput   <= '0;
      r_extMask  <= '0;
      r_ringMask <= '0;
      r_sMask    <= '0;
    end else begin
      if (w_ctrl.loadA)     r_aInput   <= la2_data_in;
      if (w_ctrl.loadB)     r_bInput   <= la3_data_in;
      if (w_ctrl.loadExt)   r_extMask  <= la2_data_in;
      if (w_ctrl.loadRing)  r_ringMask <= la2_data_in;
      if (w_ctrl.loadSMask) r_sMask    <= la3_data_in;
    end
  end

  // Ring register advances only while run is set
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_chainOut <= 1'b0;
    end else if (w_ctrl.run) begin
      r_chainOut <= w_chainNext;
    end
  end

  // Saturating count of rising ring edges; clear wins over increment
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_counter <= '0;
    end else if (w_ctrl.clear) begin
      r_counter <= '0;
    end else if (w_chainRise && (r_counter != COUNT_MAX)) begin
      r_counter <= r_counter + 1'b1;
    end
  end

  // Output gating: a deselected project drives nothing but zeros
  always_comb begin
    la1_data_out = '0;
    la2_data_out = '0;
    la3_data_out = '0;
    io_out       = '0;
    io_oeb       = '0;
    if (active) begin
      la1_data_out         = w_sum;
      la2_data_out         = r_counter;
      la3_data_out         = {w_cout, {(WIDTH-2){1'b0}}, r_chainOut};
      io_out[CHAIN_OUT]    = r_chainOut;
      io_out[COUT_OUT]     = w_cout;
      io_oeb               = '1;
      io_oeb[CHAIN_OUT]    = 1'b0;
      io_oeb[COUT_OUT]     = 1'b0;
    end
  end

endmodule

// File: tb/tb_wrapped_instrumented_adder_kogge_block.sv
// Directed testbench for the instrumented Kogge-Stone adder wrapper.
module tb_wrapped_instrumented_adder_kogge_block;

  logic        clk;
  logic        rst_n;
  logic        active;
  logic [31:0] la1_data_in, la2_data_in, la3_data_in;
  logic [31:0] la1_oenb, la2_oenb, la3_oenb;
  logic [31:0] la1_data_out, la2_data_out, la3_data_out;
  logic [37:0] io_in, io_out, io_oeb;

  int testsRun;
  int testsFailed;

  localparam logic [37:0] OEB_ACTIVE = 38'h3F_FFFF_F9FF;

  wrapped_instrumented_adder_kogge_block dut (
    .wb_clk_i     (clk),
    .rst_n        (rst_n),
    .active       (active),
    .la1_data_in  (la1_data_in),
    .la1_data_out (la1_data_out),
    .la1_oenb     (la1_oenb),
    .la2_data_in  (la2_data_in),
    .la2_data_out (la2_data_out),
    .la2_oenb     (la2_oenb),
    .la3_data_in  (la3_data_in),
    .la3_data_out (la3_data_out),
    .la3_oenb     (la3_oenb),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_oeb       (io_oeb)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] ctrl, input logic [31:0] d2, input logic [31:0] d3);
    la1_data_in = ctrl;
    la2_data_in = d2;
    la3_data_in = d3;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    @(negedge clk);
    applyStimulus(32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    #1;
    testsRun++;
    if (la1_data_out !== 32'h0 || la2_data_out !== 32'h0 || la3_data_out !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_la got %h/%h/%h expected 0/0/0", la1_data_out, la2_data_out, la3_data_out);
    end
    testsRun++;
    if (io_out !== 38'h0 || io_oeb !== OEB_ACTIVE) begin
      testsFailed++;
      $display("[TB] FAIL reset_io got out=%h oeb=%h expected out=0 oeb=%h", io_out, io_oeb, OEB_ACTIVE);
    end
  endtask

  task automatic test_adder();
    logic [31:0] aVec [7];
    logic [31:0] bVec [7];
    logic [31:0] sVec [7];
    logic        cVec [7];
    aVec = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h12345678, 32'hAAAAAAAA, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
    bVec = '{32'h00000001, 32'h00000001, 32'h9ABCDEF0, 32'h55555555, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    sVec = '{32'h00010000, 32'h00000000, 32'hACF13568, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'hFFFFFFFE};
    cVec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(32'h0000000C, aVec[i], bVec[i]);
      tick();
      applyStimulus(32'h0, 32'h0, 32'h0);
      #1;
      testsRun++;
      if (la1_data_out !== sVec[i]) begin
        testsFailed++;
        $display("[TB] FAIL add_sum[%0d] got %h expected %h", i, la1_data_out, sVec[i]);
      end
      testsRun++;
      if (la3_data_out !== {cVec[i], 31'h0} || io_out !== (38'(cVec[i]) << 10)) begin
        testsFailed++;
        $display("[TB] FAIL add_cout[%0d] got la3=%h io=%h expected cout=%0b", i, la3_data_out, io_out, cVec[i]);
      end
    end
  endtask

  task automatic test_active();
    active = 1'b0;
    #1;
    testsRun++;
    if (la1_data_out !== 0 || la2_data_out !== 0 || la3_data_out !== 0 || io_out !== 0 || io_oeb !== 0) begin
      testsFailed++;
      $display("[TB] FAIL inactive_zero got %h %h %h %h %h expected all 0", la1_data_out, la2_data_out, la3_data_out, io_out, io_oeb);
    end
    applyStimulus(32'h0000000C, 32'h00000001, 32'h00000001);
    tick();
    applyStimulus(32'h0, 32'h0, 32'h0);
    active = 1'b1;
    #1;
    testsRun++;
    if (la1_data_out !== 32'h2) begin
      testsFailed++;
      $display("[TB] FAIL inactive_load got %h expected %h", la1_data_out, 32'h2);
    end
  endtask

  task automatic test_ext();
    doReset();
    applyStimulus(32'h00000010, 32'h80000000, 32'h0);
    tick();
    applyStimulus(32'h0, 32'h0, 32'h0);
    io_in[8] = 1'b1;
    #1;
    testsRun++;
    if (la1_data_out !== 32'h80000000) begin
      testsFailed++;
      $display("[TB] FAIL ext_one got %h expected %h", la1_data_out, 32'h80000000);
    end
    io_in[8] = 1'b0;
    #1;
    testsRun++;
    if (la1_data_out !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL ext_zero got %h expected %h", la1_data_out, 32'h0);
    end
    applyStimulus(32'h00000020, 32'h80000000, 32'h0);
    tick();
    applyStimulus(32'h0, 32'h0, 32'h0);
    io_in[8] = 1'b1;
    #1;
    testsRun++;
    if (la1_data_out !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL ring_priority got %h expected %h", la1_data_out, 32'h0);
    end
    io_in[8] = 1'b0;
  endtask

  task automatic test_ring();
    doReset();
    applyStimulus(32'h00000060, 32'h00000001, 32'h00000001);
    tick();
    applyStimulus(32'h00000001, 32'h0, 32'h0);
    tick();
    testsRun++;
    if (la3_data_out !== 32'h1 || io_out !== (38'h1 << 9) || la1_data_out !== 32'h1 || la2_data_out !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL ring_first got la3=%h io=%h sum=%h cnt=%h expected 1/200/1/1", la3_data_out, io_out, la1_data_out, la2_data_out);
    end
    for (int i = 0; i < 7; i++) tick();
    testsRun++;
    if (la2_data_out !== 32'd4 || la3_data_out !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL ring_eight got cnt=%h chain=%h expected 4/0", la2_data_out, la3_data_out);
    end
    applyStimulus(32'h0, 32'h0, 32'h0);
    tick();
    testsRun++;
    if (la2_data_out !== 32'd4 || la3_data_out !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL ring_hold got cnt=%h chain=%h expected 4/0", la2_data_out, la3_data_out);
    end
  endtask

  task automatic test_clear();
    applyStimulus(32'h00000003, 32'h0, 32'h0);
    tick();
    testsRun++;
    if (la2_data_out !== 32'h0 || la3_data_out !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL clear_with_run got cnt=%h chain=%h expected 0/1", la2_data_out, la3_data_out);
    end
    applyStimulus(32'h00000001, 32'h0, 32'h0);
    tick();
    tick();
    testsRun++;
    if (la2_data_out !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL count_after_clear got %h expected %h", la2_data_out, 32'h1);
    end
    applyStimulus(32'h00000002, 32'h0, 32'h0);
    tick();
    testsRun++;
    if (la2_data_out !== 32'h0 || la3_data_out !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL clear_only got cnt=%h chain=%h expected 0/1", la2_data_out, la3_data_out);
    end
    active = 1'b0;
    applyStimulus(32'h00000001, 32'h0, 32'h0);
    tick();
    tick();
    active = 1'b1;
    #1;
    testsRun++;
    if (la2_data_out !== 32'h1 || la3_data_out !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL inactive_run got cnt=%h chain=%h expected 1/1", la2_data_out, la3_data_out);
    end
  endtask

  task automatic test_reset_mid_run();
    applyStimulus(32'h00000001, 32'h0, 32'h0);
    tick();
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (la1_data_out !== 0 || la2_data_out !== 0 || la3_data_out !== 0 || io_out !== 0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset got %h %h %h %h expected all 0", la1_data_out, la2_data_out, la3_data_out, io_out);
    end
    #2;
    rst_n = 1'b1;
    tick();
    testsRun++;
    if (la3_data_out !== 32'h1 || la2_data_out !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL midrun_first_edge got chain=%h cnt=%h expected 1/1", la3_data_out, la2_data_out);
    end
    tick();
    testsRun++;
    if (la3_data_out !== 32'h1 || la2_data_out !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL midrun_second_edge got chain=%h cnt=%h expected 1/1", la3_data_out, la2_data_out);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    applyStimulus(32'h00000004, 32'h00000001, 32'h0);
    tick();
    applyStimulus(32'h00000041, 32'h0, 32'h00000001);
    tick();
    testsRun++;
    if (la3_data_out !== 32'h1 || la2_data_out !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL mask_old_used got chain=%h cnt=%h expected 1/1", la3_data_out, la2_data_out);
    end
    applyStimulus(32'h00000001, 32'h0, 32'h0);
    tick();
    testsRun++;
    if (la3_data_out !== 32'h0 || la2_data_out !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL mask_new_used got chain=%h cnt=%h expected 0/1", la3_data_out, la2_data_out);
    end
    applyStimulus(32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    active      = 1'b1;
    io_in       = '0;
    la1_oenb    = '1;
    la2_oenb    = '1;
    la3_oenb    = '1;
    applyStimulus(32'h0, 32'h0, 32'h0);
    test_reset();
    test_adder();
    test_active();
    test_ext();
    test_ring();
    test_clear();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/wrapped_instrumented_adder_kogge_block.md
WRAPPED_INSTRUMENTED_ADDER_KOGGE_BLOCK -- requirements
Module: wrapped_instrumented_adder_kogge

Interface
REQ-001 wb_clk_i  in  1  system clock; all state on its rising edge.
REQ-002 rst_n  in  1  reset, asynchronous and active-low.
REQ-003 active  in  1  project select; 0 forces every output to zero.
REQ-004 la1_data_in  in  32  control word (bit map in REQ-012).
REQ-005 la2_data_in  in  32  write data for a_input, a_input_ext_bit_b, a_input_ring_bit_b.
REQ-006 la3_data_in  in  32  write data for b_input, s_output_bit_b.
REQ-007 la1_oenb, la2_oenb, la3_oenb  in  32 each  logic-analyser enables; accepted, functionally ignored.
REQ-008 io_in  in  38  pads; io_in[8] is the external operand bit.
REQ-009 la1_data_out  out  32  adder sum s[31:0].
REQ-010 la2_data_out  out  32  ring edge counter; la3_data_out  out  32  {cout, 30'b0, chain_out}.
REQ-011 io_out  out  38  io_out[9]=chain_out, io_out[10]=cout, others 0; io_oeb  out  38  bits 9,10 = 0, others 1.

Function
REQ-012 Control bits of la1_data_in: [0] run, [1] clear counter, [2] load a_input<=la2, [3] load b_input<=la3, [4] load a_input_ext_bit_b<=la2, [5] load a_input_ring_bit_b<=la2, [6] load s_output_bit_b<=la3; loads are level-sensitive, one write per clock while set.
REQ-013 Effective operand bit i: a_eff[i] = a_input_ring_bit_b[i] ? chain_out : (a_input_ext_bit_b[i] ? io_in[8] : a_input[i]); ring mask has priority over ext mask.
REQ-014 {cout, s} = a_eff + b_input, 33-bit unsigned, combinational Kogge-Stone prefix network (5 levels, generate/propagate).
REQ-015 fb = XOR-reduction of (s & s_output_bit_b); mask of zero gives fb=0.
REQ-016 chain_out register: when run=1, chain_out <= ~fb each clock; when run=0, chain_out holds.
REQ-017 Counter: 32-bit; increments by 1 on each clock where run=1 and chain_out transitions 0->1; saturates at 0xFFFFFFFF.
REQ-018 clear (bit 1) has priority over increment; counter is 0 on the next clock.
REQ-019 Simultaneous loads in one cycle all take effect (distinct registers); load of a mask and run in the same cycle uses the old mask for that cycle's fb.
REQ-020 active=0: la*_data_out, io_out, io_oeb all 0; internal state continues to update.

Reset
REQ-021 rst_n=0 asynchronously clears a_input, b_input, all three masks, chain_out and counter to 0.
REQ-022 Reset mid-run: registers clear immediately; with run still 1 after release, chain_out toggles from 0 on the first edge.

Structure
REQ-023 Shared package holds WIDTH=32, IO_WIDTH=38, control bit indices, io bit indices (EXT_IN=8, CHAIN_OUT=9, COUT_OUT=10).
REQ-024 One sub-module: kogge_stone_adder (WIDTH param, a, b -> sum, cout), instantiated as instrumented_adder; registers and muxing live in the wrapper.

Verification
REQ-025 Reset, active=1, load a=0x0000FFFF, b=0x00000001 -> la1_data_out=0x00010000, la3_data_out[31]=0.
REQ-026 a=0xFFFFFFFF, b=0x00000001 -> sum 0x00000000, cout=1, io_out[10]=1; active=0 -> all outputs 0.
REQ-027 Ring: b=0, masks all 0 except a_input_ring_bit_b=0x1, s_output_bit_b=0x1, run=1 -> chain_out toggles every clock, counter increments every 2 clocks (4 after 8 clocks from 0).
REQ-028 Ext bit: a_input_ext_bit_b=0x80000000, b=0, io_in[8]=1 -> sum 0x80000000; io_in[8]=0 -> sum 0.
REQ-029 Clear and run asserted together -> counter 0; counter preset near saturation by long run stays at 0xFFFFFFFF.
REQ-030 Assert rst_n=0 between clock edges during run -> all registers and outputs read 0 before next edge.
